// File: rtl/vga_dither_output.sv
// rtl/vga_dither_output.sv - 4x4 ordered-dither colour reduction with aligned sync outputs
//
// Two-stage pixel pipeline feeding the VGA connector.
//   Stage 1 registers colour, visible, syncs and the Bayer threshold for the pixel.
//   Stage 2 adds the threshold, saturates, quantises to OUT_BITS and blanks.
// Ports:
//   i_clk, i_rst_n          pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync        syncs from the sync generator
//   i_visible               pixel lies inside the active area
//   i_hpos, i_vpos          beam column / row
//   i_r, i_g, i_b           IN_BITS colour per channel
//   o_vga_hsync/vsync       syncs delayed 2 cycles
//   o_vga_r/g/b             OUT_BITS dithered colour, 2 cycles after input
//   o_frame                 2-bit frame counter that rotates the pattern rows
module vga_dither_output #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 3,
  parameter int DITHER_EN   = 1,
  parameter int TEMPORAL_EN = 1,
  parameter bit SYNC_IDLE   = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_hsync,
  input  logic                i_vsync,
  input  logic                i_visible,
  input  logic [9:0]          i_hpos,
  input  logic [9:0]          i_vpos,
  input  logic [IN_BITS-1:0]  i_r,
  input  logic [IN_BITS-1:0]  i_g,
  input  logic [IN_BITS-1:0]  i_b,
  output logic                o_vga_hsync,
  output logic                o_vga_vsync,
  output logic [OUT_BITS-1:0] o_vga_r,
  output logic [OUT_BITS-1:0] o_vga_g,
  output logic [OUT_BITS-1:0] o_vga_b,
  output logic [1:0]          o_frame
);

  // Scales the 0..15 Bayer entry to one output LSB step of the input range.
  localparam int SHIFT = IN_BITS - OUT_BITS - 4;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'd0:  v = 4'd0;
      4'd1:  v = 4'd8;
      4'd2:  v = 4'd2;
      4'd3:  v = 4'd10;
      4'd4:  v = 4'd12;
      4'd5:  v = 4'd4;
      4'd6:  v = 4'd14;
      4'd7:  v = 4'd6;
      4'd8:  v = 4'd3;
      4'd9:  v = 4'd11;
      4'd10: v = 4'd1;
      4'd11: v = 4'd9;
      4'd12: v = 4'd15;
      4'd13: v = 4'd7;
      4'd14: v = 4'd13;
      default: v = 4'd5;
    endcase
    return v;
  endfunction

  // Sum is one bit wider so an overflow saturates instead of wrapping to black.
  function automatic logic [OUT_BITS-1:0] quant(input logic [IN_BITS-1:0] c,
                                                input logic [IN_BITS-1:0] t);
    logic [IN_BITS:0] s;
    s = {1'b0, c} + {1'b0, t};
    if (s[IN_BITS]) return '1;
    return s[IN_BITS-1 -: OUT_BITS];
  endfunction

  logic [1:0]          frame_q, frame_d;
  logic [1:0]          row;
  logic [3:0]          b_val;
  logic [IN_BITS-1:0]  thr_d, thr_q;
  logic [IN_BITS-1:0]  r_q, g_q, b_q;
  logic                vis_q, hs1_q, vs1_q;
  logic                hs2_q, vs2_q;
  logic [OUT_BITS-1:0] ro_d, go_d, bo_d;
  logic [OUT_BITS-1:0] ro_q, go_q, bo_q;

  // Frame ticks at (0,0); the (0,0) pixel itself still sees the old value.
  always_comb begin
    frame_d = frame_q;
    if (i_hpos == 10'd0 && i_vpos == 10'd0) frame_d = frame_q + 2'd1;
  end

  always_comb begin
    row   = (TEMPORAL_EN != 0) ? (i_vpos[1:0] + frame_q) : i_vpos[1:0];
    b_val = bayer(row, i_hpos[1:0]);
    thr_d = (DITHER_EN != 0) ? ({{(IN_BITS-4){1'b0}}, b_val} << SHIFT) : '0;
  end

  always_comb begin
    ro_d = '0;
    go_d = '0;
    bo_d = '0;
    if (vis_q) begin
      ro_d = quant(r_q, thr_q);
      go_d = quant(g_q, thr_q);
      bo_d = quant(b_q, thr_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q <= 2'd0;
      thr_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      vis_q   <= 1'b0;
      hs1_q   <= SYNC_IDLE;
      vs1_q   <= SYNC_IDLE;
      hs2_q   <= SYNC_IDLE;
      vs2_q   <= SYNC_IDLE;
      ro_q    <= '0;
      go_q    <= '0;
      bo_q    <= '0;
    end else begin
      frame_q <= frame_d;
      thr_q   <= thr_d;
      r_q     <= i_r;
      g_q     <= i_g;
      b_q     <= i_b;
      vis_q   <= i_visible;
      hs1_q   <= i_hsync;
      vs1_q   <= i_vsync;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      ro_q    <= ro_d;
      go_q    <= go_d;
      bo_q    <= bo_d;
    end
  end

  assign o_vga_hsync = hs2_q;
  assign o_vga_vsync = vs2_q;
  assign o_vga_r     = ro_q;
  assign o_vga_g     = go_q;
  assign o_vga_b     = bo_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_vga_dither_output.sv
// tb/tb_vga_dither_output.sv - self-checking bench for vga_dither_output
module tb_vga_dither_output;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_hs, in_vs, in_vis;
  logic [9:0] in_h, in_v;
  logic [7:0] in_r, in_g, in_b;

  logic       o_hs[3];
  logic       o_vs[3];
  logic [2:0] o_r[3];
  logic [2:0] o_g[3];
  logic [2:0] o_b[3];
  logic [1:0] o_fr[3];

  int checks = 0;
  int errors = 0;

  // Instance 0: dither + temporal, 1: truncation, 2: static dither.
  int den[3] = '{1, 0, 1};
  int ten[3] = '{1, 1, 0};
  int bayer_tbl[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  int exp_t[5] = '{0, 1, 0, 1, 0};

  always #5 clk = ~clk;

  vga_dither_output #(.IN_BITS(8), .OUT_BITS(3), .DITHER_EN(1), .TEMPORAL_EN(1), .SYNC_IDLE(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(in_hs), .i_vsync(in_vs), .i_visible(in_vis),
    .i_hpos(in_h), .i_vpos(in_v), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_vga_hsync(o_hs[0]), .o_vga_vsync(o_vs[0]), .o_vga_r(o_r[0]), .o_vga_g(o_g[0]),
    .o_vga_b(o_b[0]), .o_frame(o_fr[0]));

  vga_dither_output #(.IN_BITS(8), .OUT_BITS(3), .DITHER_EN(0), .TEMPORAL_EN(1), .SYNC_IDLE(1'b1)) dut_trunc (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(in_hs), .i_vsync(in_vs), .i_visible(in_vis),
    .i_hpos(in_h), .i_vpos(in_v), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_vga_hsync(o_hs[1]), .o_vga_vsync(o_vs[1]), .o_vga_r(o_r[1]), .o_vga_g(o_g[1]),
    .o_vga_b(o_b[1]), .o_frame(o_fr[1]));

  vga_dither_output #(.IN_BITS(8), .OUT_BITS(3), .DITHER_EN(1), .TEMPORAL_EN(0), .SYNC_IDLE(1'b1)) dut_static (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(in_hs), .i_vsync(in_vs), .i_visible(in_vis),
    .i_hpos(in_h), .i_vpos(in_v), .i_r(in_r), .i_g(in_g), .i_b(in_b),
    .o_vga_hsync(o_hs[2]), .o_vga_vsync(o_vs[2]), .o_vga_r(o_r[2]), .o_vga_g(o_g[2]),
    .o_vga_b(o_b[2]), .o_frame(o_fr[2]));

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // Expected output level straight from the dithering rules.
  function automatic int exp_ch(input int c, input int de, input int te, input int f,
                                input int h, input int v);
    int rw, thr, s;
    rw  = te != 0 ? ((v % 4) + f) % 4 : v % 4;
    thr = de != 0 ? bayer_tbl[rw * 4 + (h % 4)] * 2 : 0;
    s   = c + thr;
    if (s > 255) return 7;
    return s / 32;
  endfunction

  // Model: two pipeline slots of expected values plus the frame count.
  int st_c[3][3];
  int ot_c[3][3];
  int st_hs = 1, st_vs = 1, ot_hs = 1, ot_vs = 1;
  int mframe = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 3; c++) begin
          st_c[d][c] = 0;
          ot_c[d][c] = 0;
        end
      st_hs = 1; st_vs = 1; ot_hs = 1; ot_vs = 1;
      mframe = 0;
    end else begin
      ot_c  = st_c;
      ot_hs = st_hs;
      ot_vs = st_vs;
      for (int d = 0; d < 3; d++) begin
        st_c[d][0] = in_vis ? exp_ch(int'(in_r), den[d], ten[d], mframe, int'(in_h), int'(in_v)) : 0;
        st_c[d][1] = in_vis ? exp_ch(int'(in_g), den[d], ten[d], mframe, int'(in_h), int'(in_v)) : 0;
        st_c[d][2] = in_vis ? exp_ch(int'(in_b), den[d], ten[d], mframe, int'(in_h), int'(in_v)) : 0;
      end
      st_hs = int'(in_hs);
      st_vs = int'(in_vs);
      if (in_h == 10'd0 && in_v == 10'd0) mframe = (mframe + 1) % 4;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_r%0d", d), int'(o_r[d]), ot_c[d][0]);
      chk($sformatf("model_g%0d", d), int'(o_g[d]), ot_c[d][1]);
      chk($sformatf("model_b%0d", d), int'(o_b[d]), ot_c[d][2]);
      chk($sformatf("model_hs%0d", d), int'(o_hs[d]), ot_hs);
      chk($sformatf("model_vs%0d", d), int'(o_vs[d]), ot_vs);
      chk($sformatf("model_frame%0d", d), int'(o_fr[d]), mframe);
    end
  end

  task automatic px(input int h, input int v, input int vis, input int hs, input int vs,
                    input int r, input int g, input int b);
    in_h   = 10'(h);
    in_v   = 10'(v);
    in_vis = 1'(vis);
    in_hs  = 1'(hs);
    in_vs  = 1'(vs);
    in_r   = 8'(r);
    in_g   = 8'(g);
    in_b   = 8'(b);
    @(negedge clk);
  endtask

  initial begin
    int ones;
    px(5, 5, 1, 0, 0, 200, 100, 50);
    for (int i = 0; i < 4; i++)
      px($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    chk("rst_frame", int'(o_fr[0]), 0);
    chk("rst_hsync", int'(o_hs[0]), 1);
    chk("rst_vsync", int'(o_vs[0]), 1);
    chk("rst_r", int'(o_r[1]), 0);

    rst_n = 1'b1;
    px(1, 1, 1, 1, 1, 128, 31, 255);
    chk("latency_1cyc", int'(o_r[1]), 0);
    px(2, 1, 1, 1, 1, 128, 31, 255);
    chk("latency_2cyc", int'(o_r[1]), 4);

    for (int i = 0; i < 17; i++) begin
      if (i < 16) px(4 + i % 4, 4 + i / 4, 1, 1, 1, 128, 31, 255);
      else px(8, 8, 0, 1, 1, 0, 0, 0);
      if (i >= 1) begin
        chk("trunc_r", int'(o_r[1]), 4);
        chk("trunc_g", int'(o_g[1]), 0);
        chk("trunc_b", int'(o_b[1]), 7);
      end
    end

    ones = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) px(4 + i % 4, 4 + i / 4, 1, 1, 1, 16, 16, 16);
      else px(8, 8, 0, 1, 1, 0, 0, 0);
      if (i >= 1) begin
        ones += int'(o_r[2]);
        if (i - 1 == 0) chk("dens_00", int'(o_r[2]), 0);
        if (i - 1 == 1) chk("dens_01", int'(o_r[2]), 1);
      end
    end
    chk("dens_count", ones, 8);

    px(4, 7, 1, 1, 1, 250, 0, 255);
    px(5, 7, 1, 1, 1, 0, 0, 0);
    chk("sat_250_b15", int'(o_r[2]), 7);
    chk("sat_255", int'(o_b[0]), 7);
    chk("zero_g", int'(o_g[0]), 0);
    px(6, 7, 1, 1, 1, 0, 0, 0);
    chk("zero_r", int'(o_r[0]), 0);

    px(8, 8, 1, 1, 1, 255, 255, 255);
    px(9, 8, 0, 0, 1, 255, 255, 255);
    px(10, 8, 1, 1, 1, 255, 255, 255);
    chk("blank_r", int'(o_r[0]), 0);
    chk("blank_hs", int'(o_hs[0]), 0);
    px(11, 8, 1, 1, 1, 255, 255, 255);
    chk("unblank_r", int'(o_r[0]), 7);
    chk("hs_back", int'(o_hs[0]), 1);

    for (int k = 0; k < 5; k++) begin
      chk("frame_seq", int'(o_fr[0]), k % 4);
      px(0, 0, 1, 1, 1, 16, 16, 16);
      px(1, 0, 1, 1, 1, 0, 0, 0);
      chk("temporal_00", int'(o_r[0]), exp_t[k]);
    end

    px(2, 2, 1, 0, 0, 255, 255, 255);
    px(3, 2, 1, 0, 0, 255, 255, 255);
    chk("pre_rst_r", int'(o_r[0]), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_r", int'(o_r[0]), 0);
    chk("mid_rst_hs", int'(o_hs[0]), 1);
    chk("mid_rst_frame", int'(o_fr[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    px(2, 1, 1, 1, 1, 255, 255, 255);
    chk("post_rst_1", int'(o_r[0]), 0);
    px(3, 1, 1, 1, 1, 255, 255, 255);
    chk("post_rst_2", int'(o_r[0]), 7);

    for (int i = 0; i < 60; i++)
      px($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    px(9, 9, 0, 1, 1, 0, 0, 0);
    px(9, 9, 0, 1, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
